serial_subtractor: RTL and testbench

Bit-serial subtractor: computes Diff = A - B one bit per clock, LSB first, using a single half-subtractor/full-subtractor cell and a registered borrow. It also produces ARMv8 SUBS-style condition flags N, Z, C and V.
It is the subtract-direction counterpart of the adder gate cells. It serves as a low-area multi-cycle SUB/CMP unit beside the ALU, using a start/busy/done handshake.

---
 rtl/serial_subtractor.sv | 86 ++++++++
 tb/tb_serial_subtractor.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A - B, LSB first, one subtractor cell plus a registered borrow.
// Raises ARM SUBS-style N/Z/C/V flags and uses a start/busy/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 64
) (
  input  logic             CLK,
  input  logic             resetl,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             N,
  output logic             Z,
  output logic             C,
  output logic             V
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] areg, breg, rreg, res;
  logic [CW-1:0] count;
  logic borrow, amsb, bmsb, a, b, d, nb, last;
  assign a = areg[0];
  assign b = breg[0];
  assign d = a ^ b ^ borrow;
  assign nb = (~a & b) | (~(a ^ b) & borrow);
  assign res = {d, rreg[WIDTH-1:1]};
  assign last = count == CW'(WIDTH - 1);
  always_ff @(posedge CLK or negedge resetl)
    if (!resetl) begin
      state <= IDLE;
      areg <= '0;
      breg <= '0;
      rreg <= '0;
      count <= '0;
      borrow <= 1'b0;
      amsb <= 1'b0;
      bmsb <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      Diff <= '0;
      N <= 1'b0;
      Z <= 1'b0;
      C <= 1'b0;
      V <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            areg <= A;
            breg <= B;
            borrow <= 1'b0;
            count <= '0;
            amsb <= A[WIDTH-1];
            bmsb <= B[WIDTH-1];
            busy <= 1'b1;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          rreg <= res;
          areg <= areg >> 1;
          breg <= breg >> 1;
          borrow <= nb;
          count <= count + 1'b1;
          // final bit: res already holds the complete difference
          if (last) begin
            Diff <= res;
            N <= d;
            Z <= res == '0;
            C <= ~nb;
            V <= (amsb ^ bmsb) & (d ^ amsb);
            busy <= 1'b0;
            done <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random checks of serial_subtractor at WIDTH 8 and 64
// against an arithmetic reference model.
module tb_serial_subtractor;
  logic CLK = 1'b0;
  logic resetl;
  logic st8, busy8, done8, n8, z8, c8, v8;
  logic [7:0] a8, b8, diff8;
  logic st64, busy64, done64, n64, z64, c64, v64;
  logic [63:0] a64, b64, diff64;
  int n_assert = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .CLK(CLK), .resetl(resetl), .start(st8), .A(a8), .B(b8), .busy(busy8), .done(done8),
    .Diff(diff8), .N(n8), .Z(z8), .C(c8), .V(v8));

  serial_subtractor #(.WIDTH(64)) dut64 (
    .CLK(CLK), .resetl(resetl), .start(st64), .A(a64), .B(b64), .busy(busy64), .done(done64),
    .Diff(diff64), .N(n64), .Z(z64), .C(c64), .V(v64));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // {diff, N, Z, C, V}: flags from unsigned compare and signed range check
  function automatic logic [67:0] model(input int w, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] m, d;
    logic signed [66:0] sa, sb, sd, lim;
    m = (w == 64) ? '1 : (64'd1 << w) - 64'd1;
    a &= m;
    b &= m;
    d = (a - b) & m;
    lim = 67'sd1 <<< (w - 1);
    sa = a[w-1] ? $signed({3'b0, a}) - (lim <<< 1) : $signed({3'b0, a});
    sb = b[w-1] ? $signed({3'b0, b}) - (lim <<< 1) : $signed({3'b0, b});
    sd = sa - sb;
    return {d, d[w-1], d == 64'd0, a >= b, (sd < -lim) || (sd >= lim)};
  endfunction

  task automatic launch8(input logic [7:0] a, input logic [7:0] b);
    a8 = a;
    b8 = b;
    st8 = 1'b1;
    step();
    st8 = 1'b0;
    a8 = 8'($urandom);
    b8 = 8'($urandom);
    chk("busy8_after_accept", {63'd0, busy8}, 64'd1);
  endtask

  // waits for done; optionally pokes start with other operands mid-operation
  task automatic wait8(input logic [67:0] e, input bit poke);
    int lat = 0;
    int bcnt = 0;
    while (!done8 && lat < 40) begin
      bcnt += int'(busy8);
      st8 = poke && lat == 3;
      if (st8) begin
        a8 = 8'($urandom);
        b8 = 8'($urandom);
      end
      step();
      lat++;
    end
    st8 = 1'b0;
    chk("latency8", 64'(lat), 64'd8);
    chk("busy_cycles8", 64'(bcnt), 64'd8);
    chk("busy8_in_done", {63'd0, busy8}, 64'd0);
    chk("diff8", {56'd0, diff8}, {56'd0, e[11:4]});
    chk("nzcv8", {60'd0, n8, z8, c8, v8}, {60'd0, e[3:0]});
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit poke);
    launch8(a, b);
    wait8(model(8, {56'd0, a}, {56'd0, b}), poke);
    step();
    chk("done8_one_cycle", {62'd0, done8, busy8}, 64'd0);
  endtask

  task automatic op64(input logic [63:0] a, input logic [63:0] b);
    logic [67:0] e;
    int lat = 0;
    e = model(64, a, b);
    a64 = a;
    b64 = b;
    st64 = 1'b1;
    step();
    st64 = 1'b0;
    a64 = {$urandom, $urandom};
    b64 = {$urandom, $urandom};
    while (!done64 && lat < 100) begin
      step();
      lat++;
    end
    chk("latency64", 64'(lat), 64'd64);
    chk("diff64", diff64, e[67:4]);
    chk("nzcv64", {60'd0, n64, z64, c64, v64}, {60'd0, e[3:0]});
    step();
    chk("done64_one_cycle", {63'd0, done64}, 64'd0);
  endtask

  initial begin
    logic [67:0] e1, e2;
    resetl = 1'b0;
    st8 = 1'b0;
    st64 = 1'b0;
    a8 = '0;
    b8 = '0;
    a64 = '0;
    b64 = '0;
    #12;
    chk("reset8", {51'd0, busy8, done8, diff8, n8, z8, c8, v8}, 64'd0);
    chk("reset64", diff64 | {58'd0, busy64, done64, n64, z64, c64, v64}, 64'd0);
    #1 resetl = 1'b1;
    step();
    op8(8'h05, 8'h03, 1'b0);
    op8(8'h03, 8'h05, 1'b0);
    op8(8'h80, 8'h01, 1'b0);
    op8(8'h77, 8'h77, 1'b0);
    op8(8'h5a, 8'h00, 1'b0);
    op64(64'd0, 64'd1);
    op64(64'h8000_0000_0000_0000, 64'd1);
    op8(8'h21, 8'h90, 1'b1);
    // back-to-back: start held through the done cycle
    e1 = model(8, 64'h10, 64'h20);
    e2 = model(8, 64'hc3, 64'h3c);
    launch8(8'h10, 8'h20);
    wait8(e1, 1'b0);
    launch8(8'hc3, 8'h3c);
    chk("b2b_done_low", {63'd0, done8}, 64'd0);
    chk("b2b_old_diff", {56'd0, diff8}, {56'd0, e1[11:4]});
    wait8(e2, 1'b0);
    step();
    // asynchronous reset mid-operation
    launch8(8'h99, 8'h11);
    repeat (4) step();
    #2 resetl = 1'b0;
    #1;
    chk("async_reset8", {51'd0, busy8, done8, diff8, n8, z8, c8, v8}, 64'd0);
    repeat (2) step();
    chk("no_done_in_reset", {62'd0, done8, busy8}, 64'd0);
    #2 resetl = 1'b1;
    step();
    op8(8'h42, 8'h17, 1'b0);
    for (int i = 0; i < 12; i++) op8(8'($urandom), 8'($urandom), i[0]);
    for (int i = 0; i < 3; i++) op64({$urandom, $urandom}, {$urandom, $urandom});
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
